// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the MIPS multi-cycle control sequencer: opcodes, functs, ALU codes, states.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction classifier: opcode/funct -> ALU control, mux selects and instruction class.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl_c,
  output logic       reg_dst_c,
  output logic       alu_src_c,
  output logic       mem_to_reg_c,
  output logic       is_load_c,
  output logic       is_store_c,
  output logic       illegal_c
);

  always_comb begin
    alu_ctrl_c   = ALU_ADD;
    reg_dst_c    = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    is_load_c    = 1'b0;
    is_store_c   = 1'b0;
    illegal_c    = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        reg_dst_c = 1'b1;
        unique case (funct)
          FN_ADD:  alu_ctrl_c = ALU_ADD;
          FN_SUB:  alu_ctrl_c = ALU_SUB;
          FN_AND:  alu_ctrl_c = ALU_AND;
          FN_OR:   alu_ctrl_c = ALU_OR;
          FN_NOR:  alu_ctrl_c = ALU_NOR;
          FN_SLT:  alu_ctrl_c = ALU_SLT;
          default: illegal_c  = 1'b1;
        endcase
      end
      OP_ADDI: alu_src_c = 1'b1;
      OP_LW: begin
        alu_src_c    = 1'b1;
        mem_to_reg_c = 1'b1;
        is_load_c    = 1'b1;
      end
      OP_SW: begin
        alu_src_c  = 1'b1;
        is_store_c = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_sequencer.sv
// Multi-cycle MIPS control FSM with registered datapath strobes.
// Optional perf counters (cycle_cnt, retire_cnt) when CTRL_PERF_CNT_EN is defined.
module mips_ctrl_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT     = 0,
  parameter bit          ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr_in,
  output logic [31:0] instruction,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic [3:0]  ALUCtrl,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        retired,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_pend_q, illegal_pend_d;
  logic              accept_c, mem_last_c, load_dec_c;
  logic              ready_d, mem_read_d, mem_write_d, reg_write_d, retired_d, illegal_d;

  logic [3:0] alu_ctrl_c;
  logic       reg_dst_c, alu_src_c, mem_to_reg_c, is_load_c, is_store_c, illegal_c;

  mips_alu_decode u_dec (
    .op           (instruction[31:26]),
    .funct        (instruction[5:0]),
    .alu_ctrl_c   (alu_ctrl_c),
    .reg_dst_c    (reg_dst_c),
    .alu_src_c    (alu_src_c),
    .mem_to_reg_c (mem_to_reg_c),
    .is_load_c    (is_load_c),
    .is_store_c   (is_store_c),
    .illegal_c    (illegal_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output; outputs trail the state by one cycle.
  always_comb begin
    state_d        = state_q;
    wait_d         = '0;
    accept_c       = instr_valid && instr_ready;
    mem_last_c     = (wait_q == WAIT_W'(MEM_WAIT));
    load_dec_c     = 1'b0;
    illegal_pend_d = 1'b0;
    unique case (state_q)
      S_IDLE:   if (accept_c) state_d = S_DECODE;
      S_DECODE: begin
        if (illegal_c) begin
          state_d        = ILLEGAL_HALT ? S_HALT : S_IDLE;
          illegal_pend_d = 1'b1;
        end else begin
          state_d    = S_EXEC;
          load_dec_c = 1'b1;
        end
      end
      S_EXEC:   state_d = (is_load_c || is_store_c) ? S_MEM : S_WB;
      S_MEM: begin
        if (mem_last_c) state_d = is_load_c ? S_WB : S_IDLE;
        else            wait_d  = wait_q + WAIT_W'(1);
      end
      S_WB:     state_d = S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
    // Ready only after a full idle cycle, so an accept can never repeat in DECODE.
    ready_d     = (state_q == S_IDLE) && (state_d == S_IDLE);
    mem_read_d  = is_load_c && ((state_q == S_MEM) || (state_q == S_WB));
    mem_write_d = is_store_c && (state_q == S_MEM) && mem_last_c;
    reg_write_d = (state_q == S_WB);
    retired_d   = reg_write_d || mem_write_d;
    illegal_d   = ILLEGAL_HALT ? (state_q == S_HALT) : illegal_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q         <= '0;
      illegal_pend_q <= 1'b0;
      instr_ready    <= 1'b1;
      instruction    <= '0;
      RegDst         <= 1'b0;
      ALUSrc         <= 1'b0;
      ALUCtrl        <= '0;
      MemtoReg       <= 1'b0;
      MemRead        <= 1'b0;
      MemWrite       <= 1'b0;
      RegWrite       <= 1'b0;
      retired        <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      wait_q         <= wait_d;
      illegal_pend_q <= illegal_pend_d;
      instr_ready    <= ready_d;
      if (accept_c) instruction <= instr_in;
      if (load_dec_c) begin
        RegDst   <= reg_dst_c;
        ALUSrc   <= alu_src_c;
        ALUCtrl  <= alu_ctrl_c;
        MemtoReg <= mem_to_reg_c;
      end
      MemRead  <= mem_read_d;
      MemWrite <= mem_write_d;
      RegWrite <= reg_write_d;
      retired  <= retired_d;
      illegal  <= illegal_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + CNT_W'(1);
      retire_cnt <= retire_cnt + CNT_W'(retired);
    end
  end
`endif

endmodule

// File: tb/tb_mips_ctrl_sequencer.sv
// Self-checking bench: randomized instruction stream against a timeline model of the sequencer.
module tb_mips_ctrl_sequencer;

  localparam int MW = 2;

  logic clk;
  logic rst_n;
  logic instr_valid;
  logic [31:0] instr_in;
  logic instr_ready;
  logic [31:0] instruction;
  logic reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, retired, illegal;
  logic [3:0] alu_ctrl;

  logic v1;
  logic [31:0] i1;
  logic ready1;
  logic [31:0] instruction1;
  logic reg_dst1, alu_src1, mem_read1, mem_write1, mem_to_reg1, reg_write1, retired1, illegal1;
  logic [3:0] alu_ctrl1;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt, cyc_cnt1, ret_cnt1;
  int ncyc;
`endif

  int nchk = 0;
  int npass = 0;

  // last legal decode fields and retire count, as the datapath should see them
  logic [3:0] m_alu;
  logic m_rd, m_src, m_m2r;
  int m_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_ctrl_sequencer #(.MEM_WAIT(MW), .ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_in(instr_in), .instruction(instruction), .RegDst(reg_dst), .ALUSrc(alu_src),
    .ALUCtrl(alu_ctrl), .MemRead(mem_read), .MemWrite(mem_write), .MemtoReg(mem_to_reg),
    .RegWrite(reg_write), .retired(retired), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cyc_cnt), .retire_cnt(ret_cnt)
`endif
  );

  mips_ctrl_sequencer #(.MEM_WAIT(0), .ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .instr_valid(v1), .instr_ready(ready1),
    .instr_in(i1), .instruction(instruction1), .RegDst(reg_dst1), .ALUSrc(alu_src1),
    .ALUCtrl(alu_ctrl1), .MemRead(mem_read1), .MemWrite(mem_write1), .MemtoReg(mem_to_reg1),
    .RegWrite(reg_write1), .retired(retired1), .illegal(illegal1)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cyc_cnt1), .retire_cnt(ret_cnt1)
`endif
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
`ifdef CTRL_PERF_CNT_EN
    if (rst_n) ncyc++;
`endif
    #1;
  endtask

  // 0 R-type, 1 addi, 2 lw, 3 sw, 4 illegal
  function automatic int kind_of(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00)
      return (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A}) ? 0 : 4;
    if (op == 6'h08) return 1;
    if (op == 6'h23) return 2;
    if (op == 6'h2B) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] alu_of(input logic [31:0] w);
    logic [5:0] fn;
    fn = w[5:0];
    if (w[31:26] != 6'h00) return 4'd2;
    case (fn)
      6'h20: return 4'd2;
      6'h22: return 4'd6;
      6'h24: return 4'd0;
      6'h25: return 4'd1;
      6'h27: return 4'd12;
      default: return 4'd7;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 9);
    if (sel <= 5) w[31:26] = 6'h00;
    case (sel)
      0: w[5:0] = 6'h20;
      1: w[5:0] = 6'h22;
      2: w[5:0] = 6'h24;
      3: w[5:0] = 6'h25;
      4: w[5:0] = 6'h27;
      5: w[5:0] = 6'h2A;
      6: w[31:26] = 6'h08;
      7: w[31:26] = 6'h23;
      8: w[31:26] = 6'h2B;
      default: if (w[31:26] inside {6'h00, 6'h08, 6'h23, 6'h2B}) begin
        w[31:26] = 6'h00;
        w[5:0] = 6'h01;
      end
    endcase
    return w;
  endfunction

  // Issue one instruction and check every output each cycle until ready returns.
  task automatic run_instr(input logic [31:0] w, input bit hold);
    int kd, lat, rw_at, mw_at, ret_at, ill_at, mr_lo, mr_hi;
    logic [3:0] n_alu;
    logic n_rd, n_src, n_m2r, legal, cur;
    kd = kind_of(w);
    legal = (kd != 4);
    n_alu = alu_of(w);
    n_rd = (kd == 0);
    n_src = (kd == 1 || kd == 2 || kd == 3);
    n_m2r = (kd == 2);
    rw_at = -1; mw_at = -1; ill_at = -1; mr_lo = -1; mr_hi = -2;
    case (kd)
      0, 1: begin lat = 4; rw_at = 3; end
      2: begin lat = 5 + MW; rw_at = 4 + MW; mr_lo = 3; mr_hi = 4 + MW; end
      3: begin lat = 4 + MW; mw_at = 3 + MW; end
      default: begin lat = 2; ill_at = 2; end
    endcase
    ret_at = (kd == 3) ? mw_at : rw_at;
    instr_valid = 1'b1;
    instr_in = w;
    step();
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) step();
      cur = (k >= 1) && legal;
      chk("ready", k, 32'(instr_ready), 32'(k == lat));
      chk("ir", k, instruction, w);
      chk("regwrite", k, 32'(reg_write), 32'(k == rw_at));
      chk("memwrite", k, 32'(mem_write), 32'(k == mw_at));
      chk("memread", k, 32'(mem_read), 32'(k >= mr_lo && k <= mr_hi));
      chk("retired", k, 32'(retired), 32'(k == ret_at));
      chk("illegal", k, 32'(illegal), 32'(k == ill_at));
      chk("aluctrl", k, 32'(alu_ctrl), 32'(cur ? n_alu : m_alu));
      chk("regdst", k, 32'(reg_dst), 32'(cur ? n_rd : m_rd));
      chk("alusrc", k, 32'(alu_src), 32'(cur ? n_src : m_src));
      chk("memtoreg", k, 32'(mem_to_reg), 32'(cur ? n_m2r : m_m2r));
      if (k < lat) begin
        instr_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        instr_in = $urandom;
      end
    end
    if (legal) begin
      m_alu = n_alu; m_rd = n_rd; m_src = n_src; m_m2r = n_m2r;
      m_ret++;
    end
`ifdef CTRL_PERF_CNT_EN
    chk("retire_cnt", lat, ret_cnt, 32'(m_ret));
    chk("cycle_cnt", lat, cyc_cnt, 32'(ncyc));
`endif
  endtask

  task automatic idle_gap(input int n);
    instr_valid = 1'b0;
    instr_in = $urandom;
    for (int k = 0; k < n; k++) begin
      step();
      chk("gap_ready", k, 32'(instr_ready), 32'd1);
      chk("gap_strobes", k, {28'd0, reg_write, mem_write, retired, illegal}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = '0; v1 = 1'b0; i1 = '0;
    m_alu = '0; m_rd = 1'b0; m_src = 1'b0; m_m2r = 1'b0; m_ret = 0;
`ifdef CTRL_PERF_CNT_EN
    ncyc = 0;
`endif
    step();
    step();
    chk("rst_ready", 0, 32'(instr_ready), 32'd1);
    chk("rst_ir", 0, instruction, 32'd0);
    chk("rst_ctrl", 0, {24'd0, alu_ctrl, reg_dst, alu_src, mem_to_reg, mem_read},
        32'd0);
    chk("rst_strobes", 0, {28'd0, reg_write, mem_write, retired, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_ready", 0, 32'(instr_ready), 32'd1);

    // directed: add, lw, sw, illegal, then back-to-back slt/nor/addi
    run_instr(32'h00221820, 1'b0);
    idle_gap(2);
    run_instr(32'h8C040008, 1'b0);
    run_instr(32'hAC04000C, 1'b0);
    run_instr(32'hFC000000, 1'b0);
    run_instr(32'h0022282A, 1'b1);
    run_instr(32'h00223027, 1'b1);
    run_instr(32'h20270005, 1'b1);
    idle_gap(1);

    for (int n = 0; n < 40; n++) begin
      run_instr(rand_instr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end
    instr_valid = 1'b0;

    // halting variant: add completes, then an illegal parks it
    v1 = 1'b1; i1 = 32'h00221820;
    step();
    v1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("h_regwrite", k, 32'(reg_write1), 32'(k == 3));
      chk("h_ready", k, 32'(ready1), 32'(k == 4));
    end
    chk("h_ctrl", 4, {26'd0, alu_ctrl1, reg_dst1, alu_src1}, {26'd0, 4'd2, 1'b1, 1'b0});
    v1 = 1'b1; i1 = 32'hFC000000;
    step();
    i1 = 32'h00221820;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("h_illegal", k, 32'(illegal1), 32'(k >= 2));
      chk("h_ready_low", k, 32'(ready1), 32'd0);
      chk("h_ir", k, instruction1, 32'hFC000000);
      chk("h_quiet", k, {28'd0, reg_write1, mem_write1, retired1, mem_read1}, 32'd0);
    end
    chk("h_m2r", 6, 32'(mem_to_reg1), 32'd0);
    v1 = 1'b0;

    // reset in the middle of an add's write-back
    instr_valid = 1'b1; instr_in = 32'h00221820;
    step();
    instr_valid = 1'b0;
    step(); step(); step();
    chk("wb_before_rst", 3, 32'(reg_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_regwrite", 0, 32'(reg_write), 32'd0);
    chk("rst_retired", 0, 32'(retired), 32'd0);
    chk("rst_ready_mid", 0, 32'(instr_ready), 32'd1);
    chk("rst_ir_mid", 0, instruction, 32'd0);
    chk("rst_halt_clear", 0, {30'd0, illegal1, ready1}, 32'd1);
    m_alu = '0; m_rd = 1'b0; m_src = 1'b0; m_m2r = 1'b0; m_ret = 0;
`ifdef CTRL_PERF_CNT_EN
    ncyc = 0;
`endif
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_hold_strobes", k, {28'd0, reg_write, mem_write, retired, illegal}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 0, 32'(instr_ready), 32'd1);
    chk("post_rst_strobes", 0, {28'd0, reg_write, mem_write, retired, illegal}, 32'd0);
    run_instr(32'h8C040008, 1'b0);
    run_instr(32'h00221820, 1'b1);
    instr_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
